// File: rtl/fft4_sched_if.sv
// -----------------------------------------------------------------------------
// fft4_sched_if
// Sample/result stream bundle for the fft4_sched frame sequencer.
//
//   s_valid / s_ready / s_data : input sample stream (source -> scheduler)
//   m_valid / m_ready / m_data : output result stream (scheduler -> sink)
//   m_last                     : marks bin 3 of every output frame
//
// Modports:
//   slave  - the scheduler: consumes samples, produces results
//   master - the sample source / result sink around it
// -----------------------------------------------------------------------------
interface fft4_sched_if #(
    parameter int WIDTH = 32
);
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_data;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic             m_last;

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, m_last
    );

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, m_last
    );
endinterface

// File: rtl/fft4_sched.sv
// -----------------------------------------------------------------------------
// fft4_sched
// Frame sequencer for the 4-point FFT core. Packs four input samples into a
// frame, runs the core through start/done/rearm, then streams the four bins
// back out with m_last on bin 3. One frame in flight at a time.
//
// Ports:
//   clk, rst              single clock, synchronous active-high reset
//   bus (slave)           s_valid/s_ready/s_data in, m_valid/m_ready/m_data/m_last out
//   core_rst, core_start  drive the core's rst and start
//   core_done             core done
//   core_in0..3           frame samples 0..3 presented to the core
//   core_out0..3          core results, bins 0..3
//   frame_cnt             frames fully drained (wraps)
//   err                   one-cycle watchdog pulse
//
// Optional feature: define FFT4_SCHED_WDOG_EN to enable a WAIT watchdog of
// WDOG_CYCLES cycles. Without it err is tied 0 and WAIT waits indefinitely.
// -----------------------------------------------------------------------------
module fft4_sched #(
    parameter int WIDTH       = 32,
    parameter int WDOG_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    fft4_sched_if.slave      bus,
    output logic             core_rst,
    output logic             core_start,
    input  logic             core_done,
    output logic [WIDTH-1:0] core_in0,
    output logic [WIDTH-1:0] core_in1,
    output logic [WIDTH-1:0] core_in2,
    output logic [WIDTH-1:0] core_in3,
    input  logic [WIDTH-1:0] core_out0,
    input  logic [WIDTH-1:0] core_out1,
    input  logic [WIDTH-1:0] core_out2,
    input  logic [WIDTH-1:0] core_out3,
    output logic [15:0]      frame_cnt,
    output logic             err
);

    typedef enum logic [2:0] {
        S_FILL,
        S_START,
        S_WAIT,
        S_REARM,
        S_DRAIN
    } state_t;

    state_t           state, state_nxt;
    logic [1:0]       idx;            // next input slot
    logic [1:0]       odx;            // bin currently on m_data
    logic [WIDTH-1:0] core_in_q [4];
    logic [WIDTH-1:0] result    [4];
    logic             accept, capture, take;

    assign core_in0 = core_in_q[0];
    assign core_in1 = core_in_q[1];
    assign core_in2 = core_in_q[2];
    assign core_in3 = core_in_q[3];

`ifdef FFT4_SCHED_WDOG_EN
    localparam int WCNT_W = $clog2(WDOG_CYCLES + 1);

    logic [WCNT_W-1:0] wcnt;
    logic              timed_out;     // limit reached last edge: abort this cycle
    logic              wdog_fire;     // limit reached at the coming edge
    logic              abort;
    logic              dropped;       // current REARM belongs to an aborted frame

    assign timed_out = (wcnt == WCNT_W'(WDOG_CYCLES));
`endif

    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        capture   = 1'b0;
        take      = 1'b0;
`ifdef FFT4_SCHED_WDOG_EN
        wdog_fire = 1'b0;
        abort     = 1'b0;
`endif
        case (state)
            S_FILL: begin
                accept = bus.s_valid & bus.s_ready;
                if (accept && idx == 2'd3) state_nxt = S_START;
            end
            S_START: state_nxt = S_WAIT;
            S_WAIT: begin
`ifdef FFT4_SCHED_WDOG_EN
                // Done sampled on the limit edge still wins; the err cycle
                // itself ignores done and always aborts.
                if (timed_out) begin
                    abort     = 1'b1;
                    state_nxt = S_REARM;
                end else if (core_done) begin
                    capture   = 1'b1;
                    state_nxt = S_REARM;
                end else if (wcnt == WCNT_W'(WDOG_CYCLES - 1)) begin
                    wdog_fire = 1'b1;
                end
`else
                if (core_done) begin
                    capture   = 1'b1;
                    state_nxt = S_REARM;
                end
`endif
            end
            S_REARM: begin
`ifdef FFT4_SCHED_WDOG_EN
                state_nxt = dropped ? S_FILL : S_DRAIN;
`else
                state_nxt = S_DRAIN;
`endif
            end
            S_DRAIN: begin
                take = bus.m_valid & bus.m_ready;
                if (take && odx == 2'd3) state_nxt = S_FILL;
            end
            default: state_nxt = S_FILL;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_FILL;
            idx         <= 2'd0;
            odx         <= 2'd0;
            bus.s_ready <= 1'b0;
            bus.m_valid <= 1'b0;
            bus.m_last  <= 1'b0;
            bus.m_data  <= '0;
            core_start  <= 1'b0;
            core_rst    <= 1'b1;
            core_in_q   <= '{default: '0};
            frame_cnt   <= 16'd0;
        end else begin
            state <= state_nxt;
            // Strobes are decoded from the next state so they are registered
            // and line up exactly with the state they belong to.
            bus.s_ready <= (state_nxt == S_FILL);
            core_start  <= (state_nxt == S_START);
            core_rst    <= (state_nxt == S_REARM);

            if (accept) begin
                core_in_q[idx] <= bus.s_data;
                idx            <= idx + 2'd1;
            end

            if (state == S_REARM && state_nxt == S_DRAIN) begin
                bus.m_valid <= 1'b1;
                bus.m_data  <= result[0];
                bus.m_last  <= 1'b0;
                odx         <= 2'd0;
            end

            // m_data/m_last only move on a handshake, so they hold under
            // backpressure.
            if (take) begin
                if (odx == 2'd3) begin
                    bus.m_valid <= 1'b0;
                    bus.m_last  <= 1'b0;
                    frame_cnt   <= frame_cnt + 16'd1;
                end else begin
                    odx        <= odx + 2'd1;
                    bus.m_data <= result[odx + 2'd1];
                    bus.m_last <= (odx == 2'd2);
                end
            end
        end
    end

    // NOTE: the result bank has no reset; it is only read in DRAIN, which is
    // always preceded by a capture.
    always_ff @(posedge clk) begin
        if (capture) begin
            result[0] <= core_out0;
            result[1] <= core_out1;
            result[2] <= core_out2;
            result[3] <= core_out3;
        end
    end

`ifdef FFT4_SCHED_WDOG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt    <= '0;
            err     <= 1'b0;
            dropped <= 1'b0;
        end else begin
            err <= wdog_fire;
            if (state != S_WAIT)  wcnt <= '0;
            else if (!timed_out)  wcnt <= wcnt + 1'b1;
            if (abort)                 dropped <= 1'b1;
            else if (state == S_REARM) dropped <= 1'b0;
        end
    end
`else
    logic [31:0] unused_wdog;
    assign unused_wdog = 32'(WDOG_CYCLES);
    assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_fft4_sched.sv
// -----------------------------------------------------------------------------
// tb_fft4_sched
// Directed testbench for fft4_sched. A behavioural stand-in for the core sits
// in the bench: done rises 4 cycles after start and stays high until
// core_rst; outputs are either a plain 4-point DFT (mode 0) or
// core_ink ^ 32'hFFFF0000 (mode 1). Expected results are hand-computed.
// -----------------------------------------------------------------------------
module tb_fft4_sched;
    localparam int WIDTH = 32;
    localparam int WDOG  = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fft4_sched_if #(.WIDTH(WIDTH)) bus ();

    logic             core_rst, core_start, core_done, err;
    logic [WIDTH-1:0] core_in0, core_in1, core_in2, core_in3;
    logic [WIDTH-1:0] core_out0, core_out1, core_out2, core_out3;
    logic [15:0]      frame_cnt;

    int checks   = 0;
    int failures = 0;

    fft4_sched #(.WIDTH(WIDTH), .WDOG_CYCLES(WDOG)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .core_rst  (core_rst),
        .core_start(core_start),
        .core_done (core_done),
        .core_in0  (core_in0),
        .core_in1  (core_in1),
        .core_in2  (core_in2),
        .core_in3  (core_in3),
        .core_out0 (core_out0),
        .core_out1 (core_out1),
        .core_out2 (core_out2),
        .core_out3 (core_out3),
        .frame_cnt (frame_cnt),
        .err       (err)
    );

    // ---------------- core stand-in ----------------
    int stub_mode = 0;
    bit done_en   = 1'b1;
    logic busy    = 1'b0;
    int   dcnt    = 0;

    always @(posedge clk) begin
        if (core_rst) begin
            busy <= 1'b0;
            dcnt <= 0;
        end else if (core_start) begin
            busy <= 1'b1;
            dcnt <= 0;
        end else if (busy && dcnt < 3) begin
            dcnt <= dcnt + 1;
        end
    end
    assign core_done = done_en && busy && (dcnt == 3);

    function automatic logic [31:0] pack(input int re, input int im);
        logic [15:0] r, i;
        r = re[15:0];
        i = im[15:0];
        return {r, i};
    endfunction

    always_comb begin : stub_core
        int a0, a1, a2, a3, b0, b1, b2, b3;
        a0 = $signed(core_in0[31:16]); b0 = $signed(core_in0[15:0]);
        a1 = $signed(core_in1[31:16]); b1 = $signed(core_in1[15:0]);
        a2 = $signed(core_in2[31:16]); b2 = $signed(core_in2[15:0]);
        a3 = $signed(core_in3[31:16]); b3 = $signed(core_in3[15:0]);
        if (stub_mode == 0) begin
            core_out0 = pack(a0 + a1 + a2 + a3, b0 + b1 + b2 + b3);
            core_out1 = pack(a0 - a2 + b1 - b3, b0 - b2 - a1 + a3);
            core_out2 = pack(a0 - a1 + a2 - a3, b0 - b1 + b2 - b3);
            core_out3 = pack(a0 - a2 - b1 + b3, b0 - b2 + a1 - a3);
        end else begin
            core_out0 = core_in0 ^ 32'hFFFF0000;
            core_out1 = core_in1 ^ 32'hFFFF0000;
            core_out2 = core_in2 ^ 32'hFFFF0000;
            core_out3 = core_in3 ^ 32'hFFFF0000;
        end
    end

    // core_start and core_rst must never overlap.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            checks++;
            if (core_start === 1'b1 && core_rst === 1'b1) begin
                failures++;
                $display("FAIL start_rst_overlap core_start=%b core_rst=%b required not both 1", core_start, core_rst);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d);
        int guard = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        while (bus.s_ready !== 1'b1 && guard < 100) begin
            tick();
            guard++;
        end
        checks++;
        if (guard >= 100) begin
            failures++;
            $display("FAIL push_timeout s_ready=%b required=1 data=%h", bus.s_ready, d);
        end
        tick();
        bus.s_valid = 1'b0;
    endtask

    task automatic drain_frame(input logic [31:0] e0, e1, e2, e3,
                               input int stall_bin, input int stall_n);
        logic [31:0] exp_d [4];
        logic        exp_last;
        int k      = 0;
        int stalls = 0;
        int guard  = 0;
        exp_d[0] = e0; exp_d[1] = e1; exp_d[2] = e2; exp_d[3] = e3;
        while (k < 4 && guard < 200) begin
            if (bus.m_valid === 1'b1) begin
                exp_last = (k == 3);
                checks++;
                if (bus.m_data !== exp_d[k] || bus.m_last !== exp_last) begin
                    failures++;
                    $display("FAIL drain_bin%0d m_data=%h m_last=%b required m_data=%h m_last=%b",
                             k, bus.m_data, bus.m_last, exp_d[k], exp_last);
                end
                checks++;
                if (bus.s_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL drain_s_ready bin%0d s_ready=%b required=0", k, bus.s_ready);
                end
                if (k == stall_bin && stalls < stall_n) begin
                    bus.m_ready = 1'b0;
                    stalls++;
                end else begin
                    bus.m_ready = 1'b1;
                    k++;
                end
            end else begin
                bus.m_ready = 1'b1;
            end
            tick();
            guard++;
        end
        bus.m_ready = 1'b1;
        checks++;
        if (k != 4) begin
            failures++;
            $display("FAIL drain_timeout bins_taken=%0d required=4", k);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++; if (bus.s_ready !== 1'b0) begin failures++; $display("FAIL reset_s_ready got=%b required=0", bus.s_ready); end
        checks++; if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid got=%b required=0", bus.m_valid); end
        checks++; if (bus.m_last !== 1'b0) begin failures++; $display("FAIL reset_m_last got=%b required=0", bus.m_last); end
        checks++; if (bus.m_data !== 32'h0) begin failures++; $display("FAIL reset_m_data got=%h required=0", bus.m_data); end
        checks++; if (core_start !== 1'b0) begin failures++; $display("FAIL reset_core_start got=%b required=0", core_start); end
        checks++; if (core_rst !== 1'b1) begin failures++; $display("FAIL reset_core_rst got=%b required=1", core_rst); end
        checks++; if ({core_in0, core_in1, core_in2, core_in3} !== 128'h0) begin failures++; $display("FAIL reset_core_in got=%h required=0", {core_in0, core_in1, core_in2, core_in3}); end
        checks++; if (frame_cnt !== 16'h0) begin failures++; $display("FAIL reset_frame_cnt got=%h required=0", frame_cnt); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b required=0", err); end
        rst = 1'b0;
        tick();
        checks++; if (core_rst !== 1'b0) begin failures++; $display("FAIL post_reset_core_rst got=%b required=0", core_rst); end
        checks++; if (bus.s_ready !== 1'b1) begin failures++; $display("FAIL post_reset_s_ready got=%b required=1", bus.s_ready); end
    endtask

    task automatic test_single_frame();
        int lat      = 1;
        int rearm_at = -1;
        stub_mode   = 0;
        bus.m_ready = 1'b1;
        push(32'h00010000); push(32'h00020000); push(32'h00030000); push(32'h00040000);
        // Now in the cycle right after the 4th accept.
        checks++; if (core_start !== 1'b1) begin failures++; $display("FAIL single_core_start got=%b required=1", core_start); end
        checks++; if (bus.s_ready !== 1'b0) begin failures++; $display("FAIL single_s_ready_fall got=%b required=0", bus.s_ready); end
        while (bus.m_valid !== 1'b1 && lat < 50) begin
            if (core_rst === 1'b1) rearm_at = lat;
            tick();
            lat++;
        end
        // Accept cycle is cycle 0: start 1, wait 2..5, rearm 6, m_valid 7.
        checks++; if (lat != 7) begin failures++; $display("FAIL single_latency got=%0d required=7", lat); end
        checks++; if (rearm_at != 6) begin failures++; $display("FAIL single_rearm_cycle got=%0d required=6", rearm_at); end
        // DFT of 1,2,3,4 (real): 10, -2+2j, -2, -2-2j.
        drain_frame(32'h000A0000, 32'hFFFE0002, 32'hFFFE0000, 32'hFFFEFFFE, -1, 0);
        checks++; if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL single_m_valid_drop got=%b required=0", bus.m_valid); end
        checks++; if (frame_cnt !== 16'd1) begin failures++; $display("FAIL single_frame_cnt got=%0d required=1", frame_cnt); end
        checks++; if (bus.s_ready !== 1'b1) begin failures++; $display("FAIL single_s_ready_back got=%b required=1", bus.s_ready); end
    endtask

    task automatic test_backpressure();
        stub_mode = 1;
        push(32'h11112222); push(32'h33334444); push(32'h55556666); push(32'h77778888);
        drain_frame(32'hEEEE2222, 32'hCCCC4444, 32'hAAAA6666, 32'h88888888, 1, 5);
        checks++; if (frame_cnt !== 16'd2) begin failures++; $display("FAIL bp_frame_cnt got=%0d required=2", frame_cnt); end
        checks++; if (bus.s_ready !== 1'b1) begin failures++; $display("FAIL bp_s_ready_back got=%b required=1", bus.s_ready); end
    endtask

    task automatic test_input_gaps();
        stub_mode = 1;
        push(32'h00010002); push(32'h00030004);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (core_start !== 1'b0 || bus.s_ready !== 1'b1) begin
                failures++;
                $display("FAIL gap_stall%0d core_start=%b s_ready=%b required 0/1", i, core_start, bus.s_ready);
            end
        end
        push(32'h00050006);
        checks++; if (core_start !== 1'b0) begin failures++; $display("FAIL gap_early_start got=%b required=0", core_start); end
        push(32'h00070008);
        checks++; if (core_start !== 1'b1) begin failures++; $display("FAIL gap_core_start got=%b required=1", core_start); end
        repeat (3) tick();
        checks++;
        if ({core_in0, core_in1, core_in2, core_in3} !== {32'h00010002, 32'h00030004, 32'h00050006, 32'h00070008}) begin
            failures++;
            $display("FAIL gap_core_in got=%h %h %h %h required 00010002 00030004 00050006 00070008",
                     core_in0, core_in1, core_in2, core_in3);
        end
        drain_frame(32'hFFFE0002, 32'hFFFC0004, 32'hFFFA0006, 32'hFFF80008, -1, 0);
        checks++; if (frame_cnt !== 16'd3) begin failures++; $display("FAIL gap_frame_cnt got=%0d required=3", frame_cnt); end
    endtask

    task automatic test_reset_mid_frame();
        stub_mode = 0;
        push(32'h00010000); push(32'h00020000); push(32'h00030000); push(32'h00040000);
        tick(); tick();   // now inside WAIT
        rst = 1'b1;
        tick();
        checks++; if (bus.s_ready !== 1'b0 || bus.m_valid !== 1'b0 || bus.m_last !== 1'b0) begin failures++; $display("FAIL mid_rst_stream s_ready=%b m_valid=%b m_last=%b required 0/0/0", bus.s_ready, bus.m_valid, bus.m_last); end
        checks++; if (bus.m_data !== 32'h0) begin failures++; $display("FAIL mid_rst_m_data got=%h required=0", bus.m_data); end
        checks++; if (core_rst !== 1'b1 || core_start !== 1'b0) begin failures++; $display("FAIL mid_rst_core core_rst=%b core_start=%b required 1/0", core_rst, core_start); end
        checks++; if ({core_in0, core_in1, core_in2, core_in3} !== 128'h0) begin failures++; $display("FAIL mid_rst_core_in got=%h required=0", {core_in0, core_in1, core_in2, core_in3}); end
        checks++; if (frame_cnt !== 16'd0) begin failures++; $display("FAIL mid_rst_frame_cnt got=%0d required=0", frame_cnt); end
        rst = 1'b0;
        tick();
        push(32'h00010000); push(32'h00020000); push(32'h00030000); push(32'h00040000);
        drain_frame(32'h000A0000, 32'hFFFE0002, 32'hFFFE0000, 32'hFFFEFFFE, 3, 2);
        checks++; if (frame_cnt !== 16'd1) begin failures++; $display("FAIL mid_rst_after_frame_cnt got=%0d required=1", frame_cnt); end
    endtask

    task automatic test_frame_cnt_wrap();
        force dut.frame_cnt = 16'hFFFF;
        #1;
        release dut.frame_cnt;
        checks++; if (frame_cnt !== 16'hFFFF) begin failures++; $display("FAIL wrap_preset got=%h required=ffff", frame_cnt); end
        stub_mode = 1;
        push(32'h11112222); push(32'h33334444); push(32'h55556666); push(32'h77778888);
        drain_frame(32'hEEEE2222, 32'hCCCC4444, 32'hAAAA6666, 32'h88888888, -1, 0);
        checks++; if (frame_cnt !== 16'h0) begin failures++; $display("FAIL wrap_frame_cnt got=%h required=0", frame_cnt); end
    endtask

`ifdef FFT4_SCHED_WDOG_EN
    task automatic test_watchdog();
        int cyc      = 0;
        int err_at   = -1;
        int err_n    = 0;
        int rst_at   = -1;
        int ready_at = -1;
        int mv_n     = 0;
        stub_mode = 1;
        done_en   = 1'b0;
        push(32'h00010002); push(32'h00030004); push(32'h00050006); push(32'h00070008);
        // cyc 0 is the START cycle; WAIT cycles are 1..16, err follows.
        while (ready_at < 0 && cyc < 60) begin
            tick();
            cyc++;
            if (err === 1'b1) begin err_n++; if (err_at < 0) err_at = cyc; end
            if (core_rst === 1'b1 && rst_at < 0) rst_at = cyc;
            if (bus.s_ready === 1'b1) ready_at = cyc;
            if (bus.m_valid === 1'b1) mv_n++;
        end
        checks++; if (err_at != 17) begin failures++; $display("FAIL wdog_err_cycle got=%0d required=17", err_at); end
        checks++; if (err_n != 1) begin failures++; $display("FAIL wdog_err_pulses got=%0d required=1", err_n); end
        checks++; if (rst_at != 18) begin failures++; $display("FAIL wdog_core_rst_cycle got=%0d required=18", rst_at); end
        checks++; if (ready_at != 19) begin failures++; $display("FAIL wdog_s_ready_cycle got=%0d required=19", ready_at); end
        checks++; if (mv_n != 0) begin failures++; $display("FAIL wdog_m_valid_cycles got=%0d required=0", mv_n); end
        checks++; if (frame_cnt !== 16'd0) begin failures++; $display("FAIL wdog_frame_cnt got=%0d required=0", frame_cnt); end
        done_en = 1'b1;
        push(32'h11112222); push(32'h33334444); push(32'h55556666); push(32'h77778888);
        drain_frame(32'hEEEE2222, 32'hCCCC4444, 32'hAAAA6666, 32'h88888888, -1, 0);
        checks++; if (frame_cnt !== 16'd1) begin failures++; $display("FAIL wdog_recover_frame_cnt got=%0d required=1", frame_cnt); end
    endtask
`endif

    initial begin
        rst         = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b1;
        test_reset();
        test_single_frame();
        test_backpressure();
        test_input_gaps();
        test_reset_mid_frame();
        test_frame_cnt_wrap();
`ifdef FFT4_SCHED_WDOG_EN
        test_watchdog();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
